// File: rtl/elink_frame_assembler.sv
// Receive framing stage: turns tagged decoded bytes into 76-bit MOPSHUB frames behind a one-entry buffer.
// Optional idle timeout for open frames is built when ELINK_FRAME_TIMEOUT_EN is defined.
module elink_frame_assembler #(
   parameter int FRAME_BYTES    = 10,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic        clk_40,
   input  logic        rst,
   input  logic [7:0]  data_rec_8bit,
   input  logic [1:0]  data_rec_delimiter,
   input  logic        data_rec_valid,
   output logic [75:0] frame_76bit,
   output logic        frame_valid,
   input  logic        frame_ready,
   output logic        len_err,
   output logic        overflow,
   output logic [7:0]  err_cnt,
   output logic [7:0]  drop_cnt
);

   localparam int FRAME_W = 76;
   localparam int CNT_W   = $clog2(FRAME_BYTES + 1);

   typedef enum logic [1:0] {
      IDLE,
      COLLECT,
      WAIT_EOP
   } state_t;

   state_t             r_state;
   state_t             w_stateNext;
   logic [CNT_W-1:0]   r_byteCnt;
   logic [FRAME_W-1:0] r_shift;
   logic [FRAME_W-1:0] r_frame;
   logic               r_frameValid;
   logic               r_lenErr;
   logic               r_overflow;
   logic [7:0]         r_errCnt;
   logic [7:0]         r_dropCnt;

   logic w_sop;
   logic w_eop;
   logic w_data;
   logic w_activeStrobe;
   logic w_cntClear;
   logic w_cntInc;
   logic w_shiftEn;
   logic w_lenErr;
   logic w_frameDone;
   logic w_timeout;
   logic w_errEvent;
   logic w_dropEvent;

   assign w_sop          = data_rec_valid && (data_rec_delimiter == 2'b10);
   assign w_eop          = data_rec_valid && (data_rec_delimiter == 2'b01);
   assign w_data         = data_rec_valid && (data_rec_delimiter == 2'b00);
   assign w_activeStrobe = w_sop || w_eop || w_data;

`ifdef ELINK_FRAME_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [TO_W-1:0] r_idleCnt;

   // Counts cycles without a meaningful strobe while a frame is open.
   always_ff @(posedge clk_40) begin
      if (rst || (r_state == IDLE) || w_activeStrobe) begin
         r_idleCnt <= '0;
      end else begin
         r_idleCnt <= r_idleCnt + 1'b1;
      end
   end

   assign w_timeout = (r_state != IDLE) && !w_activeStrobe &&
                      (r_idleCnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
   assign w_timeout = 1'b0;
`endif

   always_ff @(posedge clk_40) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_stateNext;
      end
   end

   // Next-state decode; SOP inside an open frame restarts collection rather than dropping the new frame.
   always_comb begin
      w_stateNext = r_state;
      w_cntClear  = 1'b0;
      w_cntInc    = 1'b0;
      w_shiftEn   = 1'b0;
      w_lenErr    = 1'b0;
      w_frameDone = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_sop) begin
               w_cntClear  = 1'b1;
               w_stateNext = COLLECT;
            end
         end
         COLLECT: begin
            if (w_data) begin
               w_shiftEn = 1'b1;
               w_cntInc  = 1'b1;
               if (r_byteCnt == CNT_W'(FRAME_BYTES - 1)) begin
                  w_stateNext = WAIT_EOP;
               end
            end else if (w_eop) begin
               w_lenErr    = 1'b1;
               w_stateNext = IDLE;
            end else if (w_sop) begin
               w_lenErr    = 1'b1;
               w_cntClear  = 1'b1;
               w_stateNext = COLLECT;
            end
         end
         WAIT_EOP: begin
            if (w_eop) begin
               w_frameDone = 1'b1;
               w_stateNext = IDLE;
            end else if (w_data) begin
               w_lenErr    = 1'b1;
               w_stateNext = IDLE;
            end else if (w_sop) begin
               w_lenErr    = 1'b1;
               w_cntClear  = 1'b1;
               w_stateNext = COLLECT;
            end
         end
         default: begin
            w_stateNext = IDLE;
         end
      endcase
      if (w_timeout) begin
         w_stateNext = IDLE;
      end
   end

   // Only the low 76 bits of the 80 received bits reach the frame, so older bits simply fall off the top.
   always_ff @(posedge clk_40) begin
      if (rst) begin
         r_byteCnt <= '0;
         r_shift   <= '0;
      end else begin
         if (w_cntClear) begin
            r_byteCnt <= '0;
         end else if (w_cntInc) begin
            r_byteCnt <= r_byteCnt + 1'b1;
         end
         if (w_shiftEn) begin
            r_shift <= {r_shift[FRAME_W-9:0], data_rec_8bit};
         end
      end
   end

   assign w_errEvent  = w_lenErr || w_timeout;
   assign w_dropEvent = w_frameDone && r_frameValid && !frame_ready;

   // One-entry output buffer; a completion coinciding with an accept refills it instead of dropping.
   always_ff @(posedge clk_40) begin
      if (rst) begin
         r_frame      <= '0;
         r_frameValid <= 1'b0;
         r_lenErr     <= 1'b0;
         r_overflow   <= 1'b0;
         r_errCnt     <= '0;
         r_dropCnt    <= '0;
      end else begin
         r_lenErr   <= w_lenErr;
         r_overflow <= w_dropEvent;
         if (w_frameDone && !w_dropEvent) begin
            r_frame      <= r_shift;
            r_frameValid <= 1'b1;
         end else if (r_frameValid && frame_ready) begin
            r_frameValid <= 1'b0;
         end
         if (w_errEvent && (r_errCnt != 8'hFF)) begin
            r_errCnt <= r_errCnt + 8'd1;
         end
         if (w_dropEvent && (r_dropCnt != 8'hFF)) begin
            r_dropCnt <= r_dropCnt + 8'd1;
         end
      end
   end

   assign frame_76bit = r_frame;
   assign frame_valid = r_frameValid;
   assign len_err     = r_lenErr;
   assign overflow    = r_overflow;
   assign err_cnt     = r_errCnt;
   assign drop_cnt    = r_dropCnt;

endmodule

// File: tb/tb_elink_frame_assembler.sv
// Directed bench for elink_frame_assembler: framing, length errors, backpressure, timeout and reset.
module tb_elink_frame_assembler;

   localparam logic [75:0] FRAME_NOM = 76'hA112233445566778899;
   localparam logic [75:0] FRAME_30  = 76'h0313233343536373839;
   localparam logic [75:0] FRAME_50  = 76'h0515253545556575859;
   localparam logic [75:0] FRAME_C0  = 76'h0C1C2C3C4C5C6C7C8C9;
   localparam logic [75:0] FRAME_E0  = 76'h0E1E2E3E4E5E6E7E8E9;

   logic        clk_40;
   logic        rst;
   logic [7:0]  data_rec_8bit;
   logic [1:0]  data_rec_delimiter;
   logic        data_rec_valid;
   logic [75:0] frame_76bit;
   logic        frame_valid;
   logic        frame_ready;
   logic        len_err;
   logic        overflow;
   logic [7:0]  err_cnt;
   logic [7:0]  drop_cnt;

   int errors;
   int checks;
   logic [7:0] txBytes [10];

   elink_frame_assembler #(
      .FRAME_BYTES(10),
      .TIMEOUT_CYCLES(16)
   ) dut (
      .clk_40(clk_40),
      .rst(rst),
      .data_rec_8bit(data_rec_8bit),
      .data_rec_delimiter(data_rec_delimiter),
      .data_rec_valid(data_rec_valid),
      .frame_76bit(frame_76bit),
      .frame_valid(frame_valid),
      .frame_ready(frame_ready),
      .len_err(len_err),
      .overflow(overflow),
      .err_cnt(err_cnt),
      .drop_cnt(drop_cnt)
   );

   initial begin
      clk_40 = 1'b0;
      forever #5 clk_40 = ~clk_40;
   end

   // Every helper leaves the bench 1 time unit after a rising edge, where outputs are sampled.
   task automatic sendByte(input logic [1:0] tag, input logic [7:0] d);
      data_rec_valid     = 1'b1;
      data_rec_delimiter = tag;
      data_rec_8bit      = d;
      @(posedge clk_40);
      #1;
      data_rec_valid     = 1'b0;
      data_rec_delimiter = 2'b11;
      data_rec_8bit      = 8'h00;
   endtask

   task automatic idleCycles(input int n);
      repeat (n) begin
         @(posedge clk_40);
         #1;
      end
   endtask

   task automatic setPattern(input logic [7:0] base);
      for (int i = 0; i < 10; i++) txBytes[i] = base + 8'(i);
   endtask

   task automatic setNominal();
      txBytes[0] = 8'h0A; txBytes[1] = 8'h11; txBytes[2] = 8'h22; txBytes[3] = 8'h33;
      txBytes[4] = 8'h44; txBytes[5] = 8'h55; txBytes[6] = 8'h66; txBytes[7] = 8'h77;
      txBytes[8] = 8'h88; txBytes[9] = 8'h99;
   endtask

   task automatic sendBytes(input int first, input int n);
      for (int i = first; i < first + n; i++) sendByte(2'b00, txBytes[i]);
   endtask

   task automatic sendFrame();
      sendByte(2'b10, 8'h00);
      sendBytes(0, 10);
      sendByte(2'b01, 8'h00);
   endtask

   task automatic applyReset();
      rst = 1'b1;
      idleCycles(2);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idleCycles(2);
      checks++;
      if (frame_76bit !== 76'h0) begin errors++; $display("[TB] FAIL reset_frame: got %h expected 0", frame_76bit); end
      checks++;
      if (frame_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", frame_valid); end
      checks++;
      if ({len_err, overflow} !== 2'b00) begin errors++; $display("[TB] FAIL reset_pulses: got %b expected 00", {len_err, overflow}); end
      checks++;
      if ({err_cnt, drop_cnt} !== 16'h0) begin errors++; $display("[TB] FAIL reset_counts: got %h expected 0000", {err_cnt, drop_cnt}); end
      rst = 1'b0;
      idleCycles(1);
   endtask

   task automatic test_nominal();
      frame_ready = 1'b1;
      setNominal();
      sendByte(2'b10, 8'h00);
      sendBytes(0, 10);
      checks++;
      if (frame_valid !== 1'b0) begin errors++; $display("[TB] FAIL nominal_before_eop: got %b expected 0", frame_valid); end
      sendByte(2'b01, 8'h00);
      checks++;
      if (frame_valid !== 1'b1) begin errors++; $display("[TB] FAIL nominal_valid: got %b expected 1", frame_valid); end
      checks++;
      if (frame_76bit !== FRAME_NOM) begin errors++; $display("[TB] FAIL nominal_frame: got %h expected %h", frame_76bit, FRAME_NOM); end
      checks++;
      if (err_cnt !== 8'd0) begin errors++; $display("[TB] FAIL nominal_err_cnt: got %0d expected 0", err_cnt); end
      idleCycles(1);
      checks++;
      if (frame_valid !== 1'b0) begin errors++; $display("[TB] FAIL nominal_accept: got %b expected 0", frame_valid); end
   endtask

   task automatic test_short_long();
      setPattern(8'h30);
      sendByte(2'b10, 8'h00);
      sendBytes(0, 9);
      sendByte(2'b01, 8'h00);
      checks++;
      if (len_err !== 1'b1) begin errors++; $display("[TB] FAIL short_len_err: got %b expected 1", len_err); end
      checks++;
      if (err_cnt !== 8'd1) begin errors++; $display("[TB] FAIL short_err_cnt: got %0d expected 1", err_cnt); end
      checks++;
      if (frame_valid !== 1'b0) begin errors++; $display("[TB] FAIL short_no_valid: got %b expected 0", frame_valid); end
      idleCycles(1);
      checks++;
      if (len_err !== 1'b0) begin errors++; $display("[TB] FAIL short_pulse_width: got %b expected 0", len_err); end
      sendByte(2'b10, 8'h00);
      sendBytes(0, 10);
      sendByte(2'b00, 8'h5A);
      checks++;
      if (len_err !== 1'b1) begin errors++; $display("[TB] FAIL long_len_err: got %b expected 1", len_err); end
      checks++;
      if (err_cnt !== 8'd2) begin errors++; $display("[TB] FAIL long_err_cnt: got %0d expected 2", err_cnt); end
      sendByte(2'b01, 8'h00);
      checks++;
      if ({frame_valid, err_cnt} !== {1'b0, 8'd2}) begin errors++; $display("[TB] FAIL long_stray_eop: got valid=%b err=%0d expected valid=0 err=2", frame_valid, err_cnt); end
   endtask

   task automatic test_sop_restart();
      setPattern(8'h30);
      sendByte(2'b10, 8'h00);
      sendBytes(0, 4);
      sendByte(2'b10, 8'h00);
      checks++;
      if ({len_err, err_cnt} !== {1'b1, 8'd3}) begin errors++; $display("[TB] FAIL restart_err: got len=%b err=%0d expected len=1 err=3", len_err, err_cnt); end
      sendBytes(0, 10);
      sendByte(2'b01, 8'h00);
      checks++;
      if ({frame_valid, frame_76bit} !== {1'b1, FRAME_30}) begin errors++; $display("[TB] FAIL restart_frame: got %b %h expected 1 %h", frame_valid, frame_76bit, FRAME_30); end
      idleCycles(1);
   endtask

   task automatic test_backpressure();
      frame_ready = 1'b0;
      setPattern(8'h50);
      sendFrame();
      checks++;
      if ({frame_valid, frame_76bit} !== {1'b1, FRAME_50}) begin errors++; $display("[TB] FAIL bp_first: got %b %h expected 1 %h", frame_valid, frame_76bit, FRAME_50); end
      setPattern(8'h30);
      sendFrame();
      checks++;
      if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL bp_overflow: got %b expected 1", overflow); end
      checks++;
      if (drop_cnt !== 8'd1) begin errors++; $display("[TB] FAIL bp_drop_cnt: got %0d expected 1", drop_cnt); end
      checks++;
      if (frame_76bit !== FRAME_50) begin errors++; $display("[TB] FAIL bp_retained: got %h expected %h", frame_76bit, FRAME_50); end
      idleCycles(1);
      checks++;
      if ({overflow, frame_valid} !== 2'b01) begin errors++; $display("[TB] FAIL bp_after: got ovf=%b valid=%b expected ovf=0 valid=1", overflow, frame_valid); end
      frame_ready = 1'b1;
      idleCycles(1);
      checks++;
      if (frame_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_accept: got %b expected 0", frame_valid); end
   endtask

   task automatic test_same_cycle();
      frame_ready = 1'b0;
      setPattern(8'hC0);
      sendFrame();
      checks++;
      if ({frame_valid, frame_76bit} !== {1'b1, FRAME_C0}) begin errors++; $display("[TB] FAIL same_first: got %b %h expected 1 %h", frame_valid, frame_76bit, FRAME_C0); end
      setPattern(8'hE0);
      sendByte(2'b10, 8'h00);
      sendBytes(0, 10);
      frame_ready = 1'b1;
      sendByte(2'b01, 8'h00);
      checks++;
      if ({frame_valid, frame_76bit} !== {1'b1, FRAME_E0}) begin errors++; $display("[TB] FAIL same_reload: got %b %h expected 1 %h", frame_valid, frame_76bit, FRAME_E0); end
      checks++;
      if ({overflow, drop_cnt} !== {1'b0, 8'd1}) begin errors++; $display("[TB] FAIL same_no_drop: got ovf=%b drop=%0d expected ovf=0 drop=1", overflow, drop_cnt); end
      idleCycles(1);
      checks++;
      if (frame_valid !== 1'b0) begin errors++; $display("[TB] FAIL same_accept: got %b expected 0", frame_valid); end
   endtask

`ifdef ELINK_FRAME_TIMEOUT_EN
   task automatic test_timeout();
      applyReset();
      frame_ready = 1'b1;
      setPattern(8'h30);
      sendByte(2'b10, 8'h00);
      sendBytes(0, 3);
      idleCycles(15);
      checks++;
      if (err_cnt !== 8'd0) begin errors++; $display("[TB] FAIL timeout_early: got %0d expected 0", err_cnt); end
      idleCycles(1);
      checks++;
      if ({err_cnt, len_err} !== {8'd1, 1'b0}) begin errors++; $display("[TB] FAIL timeout_abort: got err=%0d len=%b expected err=1 len=0", err_cnt, len_err); end
      setNominal();
      sendFrame();
      checks++;
      if ({frame_valid, frame_76bit, err_cnt} !== {1'b1, FRAME_NOM, 8'd1}) begin errors++; $display("[TB] FAIL timeout_next: got %b %h %0d expected 1 %h 1", frame_valid, frame_76bit, err_cnt, FRAME_NOM); end
      idleCycles(1);
   endtask
`else
   task automatic test_no_timeout();
      frame_ready = 1'b1;
      setPattern(8'h30);
      sendByte(2'b10, 8'h00);
      sendBytes(0, 3);
      idleCycles(40);
      sendBytes(3, 7);
      sendByte(2'b01, 8'h00);
      checks++;
      if ({frame_valid, frame_76bit} !== {1'b1, FRAME_30}) begin errors++; $display("[TB] FAIL no_timeout_frame: got %b %h expected 1 %h", frame_valid, frame_76bit, FRAME_30); end
      checks++;
      if (err_cnt !== 8'd3) begin errors++; $display("[TB] FAIL no_timeout_err_cnt: got %0d expected 3", err_cnt); end
      idleCycles(1);
   endtask
`endif

   task automatic test_reset_mid();
      frame_ready = 1'b0;
      setPattern(8'h50);
      sendFrame();
      setNominal();
      sendByte(2'b10, 8'h00);
      sendBytes(0, 5);
      rst = 1'b1;
      idleCycles(1);
      checks++;
      if ({frame_valid, frame_76bit} !== {1'b0, 76'h0}) begin errors++; $display("[TB] FAIL rstmid_buffer: got %b %h expected 0 0", frame_valid, frame_76bit); end
      checks++;
      if ({err_cnt, drop_cnt} !== 16'h0) begin errors++; $display("[TB] FAIL rstmid_counts: got %h expected 0000", {err_cnt, drop_cnt}); end
      rst = 1'b0;
      sendBytes(5, 5);
      sendByte(2'b01, 8'h00);
      checks++;
      if ({frame_valid, err_cnt, len_err} !== {1'b0, 8'd0, 1'b0}) begin errors++; $display("[TB] FAIL rstmid_tail_ignored: got valid=%b err=%0d len=%b expected 0 0 0", frame_valid, err_cnt, len_err); end
      frame_ready = 1'b1;
      sendFrame();
      checks++;
      if ({frame_valid, frame_76bit, err_cnt} !== {1'b1, FRAME_NOM, 8'd0}) begin errors++; $display("[TB] FAIL rstmid_next: got %b %h %0d expected 1 %h 0", frame_valid, frame_76bit, err_cnt, FRAME_NOM); end
      idleCycles(1);
   endtask

   initial begin
      errors             = 0;
      checks             = 0;
      rst                = 1'b1;
      data_rec_8bit      = 8'h00;
      data_rec_delimiter = 2'b11;
      data_rec_valid     = 1'b0;
      frame_ready        = 1'b0;
      test_reset();
      test_nominal();
      test_short_long();
      test_sop_restart();
      test_backpressure();
      test_same_cycle();
`ifdef ELINK_FRAME_TIMEOUT_EN
      test_timeout();
`else
      test_no_timeout();
`endif
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/elink_frame_assembler.md
# elink_frame_assembler

Receive-side framing stage directly downstream of the 8b10b decoder in the elink core. Consumes decoded bytes plus their 2-bit delimiter tag and assembles them into 76-bit MOPSHUB frames. Presents each complete frame on a one-entry valid/ready output buffer, and counts length errors and drops. Feeds the 76-bit receive-frame consumer, which is the same format as the transmit frame handed to the encoder.

## Interface
- `FRAME_BYTES`, 10: data bytes per frame; the 76-bit frame is taken from 80 received bits.
- `TIMEOUT_CYCLES`, 1024: idle cycles before an open frame is aborted. Used only with the timeout option (see Configuration).
- `clk_40`  in  1  byte-domain clock; all logic is on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `data_rec_8bit`  in  8  decoded byte.
- `data_rec_delimiter`  in  2  tag for the byte: 2'b00 data, 2'b10 SOP, 2'b01 EOP, 2'b11 idle/comma.
- `data_rec_valid`  in  1  byte strobe; the byte and tag are sampled only while this is high.
- `frame_76bit`  out  76  assembled frame.
- `frame_valid`  out  1  frame available.
- `frame_ready`  in  1  consumer accepts the frame.
- `len_err`  out  1  one-cycle pulse on a length error.
- `overflow`  out  1  one-cycle pulse when a completed frame is dropped.
- `err_cnt`  out  8  saturating count of length and timeout errors.
- `drop_cnt`  out  8  saturating count of dropped frames.

## Operation
- **States:** IDLE, COLLECT, WAIT_EOP.
- **IDLE:**
  - An SOP strobe clears the byte counter and goes to COLLECT. The SOP byte carries no payload.
  - Data, EOP and idle strobes are ignored.
- **COLLECT:**
  - Each data strobe shifts the byte into an 80-bit shift register, MSB first, and increments the counter.
  - When the counter reaches `FRAME_BYTES`, the state moves to WAIT_EOP.
- **WAIT_EOP:**
  - EOP completes the frame and returns to IDLE.
  - A data strobe is a length error (too long); return to IDLE.
- **Both COLLECT and WAIT_EOP:**
  - EOP in COLLECT is a length error (too short); return to IDLE.
  - SOP is a length error; the counter restarts and the state goes to COLLECT, so the new frame is kept.
  - Idle strobes are ignored.
- **Frame mapping:** `frame_76bit` = shift register bits [75:0]. Byte 0 bits [7:4] are discarded and byte 0 bits [3:0] become frame bits [75:72].
- **Length error:** pulse `len_err`, increment `err_cnt` with saturation at 255, discard the partial frame.
- **Output buffer:**
  - A completed frame loads `frame_76bit` and sets `frame_valid`.
  - `frame_valid` clears on a cycle where `frame_valid` and `frame_ready` are both high.
  - While `frame_valid` is high, `frame_76bit` holds stable.
- **Full buffer:** if a frame completes while `frame_valid` is high and `frame_ready` is low:
  - the new frame is dropped and the buffered frame is retained;
  - `overflow` pulses and `drop_cnt` increments, saturating at 255.
- **Complete and accept in the same cycle:** the new frame loads and `frame_valid` stays high. This is not an overflow.

## Timing
- **Reset values:** state IDLE; `frame_76bit`=0, `frame_valid`=0, `len_err`=0, `overflow`=0, `err_cnt`=0, `drop_cnt`=0; counter 0.
- **Latency:** EOP sampled at edge N → `frame_valid` high after edge N; the consumer sees it in cycle N+1.
- **Pulse timing:** `len_err` and `overflow` are high for exactly the one cycle after the offending edge.
- **Back-to-back strobes:** `data_rec_valid` may be high every cycle and must be handled.
- **Reset mid-frame:** the partial frame is lost silently; no error is counted.
- **Reset with `frame_valid` high:** the buffered frame is discarded.
- **Counters:** count events at the same edge as the corresponding pulse and never wrap.

## Configuration
- **`ELINK_FRAME_TIMEOUT_EN` defined:**
  - A counter of `clk_40` cycles without a data, SOP or EOP strobe runs in COLLECT and WAIT_EOP.
  - When the counter reaches `TIMEOUT_CYCLES`, the frame is aborted: return to IDLE, increment `err_cnt`. `len_err` is not pulsed.
  - The counter clears on every data, SOP or EOP strobe and in IDLE.
- **`ELINK_FRAME_TIMEOUT_EN` undefined:**
  - No timeout logic; an open frame waits indefinitely.
  - `TIMEOUT_CYCLES` is unused.

## Test plan
- **Nominal frame:** SOP, bytes 8'h0A,8'h11,8'h22,8'h33,8'h44,8'h55,8'h66,8'h77,8'h88,8'h99, EOP, `frame_ready`=1 → `frame_76bit`=76'hA_1122_3344_5566_7788_99, `frame_valid` high 1 cycle after EOP, `err_cnt`=0.
- **Short and long frames:**
  - SOP + 9 bytes + EOP → `len_err` pulse, `err_cnt`=1, no `frame_valid`.
  - SOP + 11 bytes → `err_cnt`=2.
- **Backpressure:**
  - `frame_ready`=0, two complete frames A then B → `frame_76bit` stays at A, `overflow` pulses once, `drop_cnt`=1.
  - Then raise `frame_ready` → A accepted, `frame_valid` falls.
- **Same-cycle completion and accept:** frame completes on the exact cycle `frame_ready` accepts the prior frame → new frame loaded, no overflow.
- **Timeout (`ELINK_FRAME_TIMEOUT_EN`, `TIMEOUT_CYCLES`=16):** SOP + 3 bytes, then idle 16 cycles → `err_cnt`=1, back in IDLE. A following nominal frame assembles correctly.
- **Reset mid-frame:** `rst` asserted after byte 5 → all outputs 0. A following nominal frame is correct and `err_cnt`=0.
